// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg
// Shared types and constants for the PWM audio output stage.
//   state_t        : FSM state encoding (IDLE, RUN)
//   SAMPLE_W_DEF   : default incoming sample width
//   PWM_W_DEF      : default PWM resolution in bits
//   period_max()   : last counter value of a PWM period (2**pwm_w - 1)
package pwm_audio_pkg;

   localparam int SAMPLE_W_DEF = 12;
   localparam int PWM_W_DEF    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int period_max(input int pwm_w);
      return (1 << pwm_w) - 1;
   endfunction

endpackage

// File: rtl/pwm_audio_dither.sv
// pwm_audio_dither
// Combinational first-order error feedback: folds the sample bits below the
// PWM resolution into a running residual and carries overflow into the duty.
// Only instantiated when PWM_AUDIO_DITHER_EN is defined.
// Ports:
//   sample_i    : full-width sample being loaded
//   residual_i  : residual carried from the previous load
//   duty_o      : duty for the coming period (saturates at all-ones)
//   residual_o  : residual to keep for the next load
module pwm_audio_dither #(
   parameter int SAMPLE_W = 12,
   parameter int PWM_W    = 8
) (
   input  logic [SAMPLE_W-1:0]       sample_i,
   input  logic [SAMPLE_W-PWM_W-1:0] residual_i,
   output logic [PWM_W-1:0]          duty_o,
   output logic [SAMPLE_W-PWM_W-1:0] residual_o
);

   localparam int RES_W = SAMPLE_W - PWM_W;

   logic [RES_W:0]   sum;
   logic [PWM_W-1:0] upper;

   assign sum        = {1'b0, sample_i[RES_W-1:0]} + {1'b0, residual_i};
   assign upper      = sample_i[SAMPLE_W-1 -: PWM_W];
   assign residual_o = sum[RES_W-1:0];

   // A carry into an already full-scale duty would wrap to 0; clamp instead.
   assign duty_o = (sum[RES_W] && (&upper)) ? '1 : upper + PWM_W'(sum[RES_W]);

endmodule

// File: rtl/pwm_audio_out.sv
// pwm_audio_out
// Final audio stage: double-buffers 12-bit mixed samples behind a valid/ready
// handshake and plays each one as a single fixed-length PWM period on the
// audio pin. One sample is consumed per period of 2**PWM_W clocks.
// Optional build macro: PWM_AUDIO_DITHER_EN adds first-order error-feedback
// dithering of the sample bits below the PWM resolution.
// Ports:
//   clk          : system clock
//   n_rst        : asynchronous active-low reset
//   enable       : run PWM; low forces IDLE (shadow contents kept)
//   sample       : unsigned mixed sample
//   sample_valid : sample is presented
//   sample_ready : shadow register empty (transfer on valid && ready)
//   pwm_out      : registered PWM output
//   period_start : one-cycle pulse when a new period begins
//   underrun     : one-cycle pulse when a period begins with no new sample
//
// state | meaning
// IDLE  | counter held at 0, output low, waiting for enable and a sample
// RUN   | counting through a PWM period, reloading duty on the wrap cycle
module pwm_audio_out
   import pwm_audio_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int PWM_W    = PWM_W_DEF
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                pwm_out,
   output logic                period_start,
   output logic                underrun
);

   localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'(period_max(PWM_W));

   state_t              state_q;
   logic [PWM_W-1:0]    cnt_q;
   logic [PWM_W-1:0]    duty_q;
   logic [SAMPLE_W-1:0] shadow_q;
   logic                shadow_full_q;
   logic                pwm_q;
   logic                period_start_q;
   logic                underrun_q;

   logic                accept;
   logic                consume;
   logic [PWM_W-1:0]    load_duty_d;

`ifdef PWM_AUDIO_DITHER_EN
   logic [SAMPLE_W-PWM_W-1:0] residual_q;
   logic [SAMPLE_W-PWM_W-1:0] residual_d;

   pwm_audio_dither #(
      .SAMPLE_W (SAMPLE_W),
      .PWM_W    (PWM_W)
   ) u_dither (
      .sample_i   (shadow_q),
      .residual_i (residual_q),
      .duty_o     (load_duty_d),
      .residual_o (residual_d)
   );
`else
   logic unused_shadow_lsbs;

   assign load_duty_d        = shadow_q[SAMPLE_W-1 -: PWM_W];
   assign unused_shadow_lsbs = ^shadow_q[SAMPLE_W-PWM_W-1:0];
`endif

   assign sample_ready = ~shadow_full_q;
   assign accept       = sample_valid & ~shadow_full_q;
   // Consume happens on the IDLE->RUN load or on the wrap cycle in RUN.
   assign consume      = enable & shadow_full_q &
                         ((state_q == IDLE) | (cnt_q == CNT_MAX));

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign underrun     = underrun_q;

   // Accept and consume are mutually exclusive: accept needs the shadow empty,
   // consume needs it full. A sample accepted on the wrap cycle waits a period.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
      end else if (consume) begin
         shadow_full_q <= 1'b0;
      end else if (accept) begin
         shadow_q      <= sample;
         shadow_full_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         duty_q         <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         underrun_q     <= 1'b0;
`ifdef PWM_AUDIO_DITHER_EN
         residual_q     <= '0;
`endif
      end else begin
         period_start_q <= 1'b0;
         underrun_q     <= 1'b0;
         // Output lags the counter by one cycle; on the wrap cycle cnt==max
         // is never below an 8-bit duty, so full scale still has one low cycle.
         pwm_q          <= (state_q == RUN) && (cnt_q < duty_q);
         if (!enable) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
`ifdef PWM_AUDIO_DITHER_EN
            residual_q <= '0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  if (shadow_full_q) begin
                     duty_q         <= load_duty_d;
                     period_start_q <= 1'b1;
                     state_q        <= RUN;
`ifdef PWM_AUDIO_DITHER_EN
                     residual_q     <= residual_d;
`endif
                  end else begin
`ifdef PWM_AUDIO_DITHER_EN
                     residual_q     <= '0;
`endif
                  end
               end
               RUN: begin
                  cnt_q <= cnt_q + PWM_W'(1);
                  if (cnt_q == CNT_MAX) begin
                     period_start_q <= 1'b1;
                     if (shadow_full_q) begin
                        duty_q     <= load_duty_d;
`ifdef PWM_AUDIO_DITHER_EN
                        residual_q <= residual_d;
`endif
                     end else begin
                        underrun_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
// Randomised and directed stimulus against a period-level behavioural model.
// Honours PWM_AUDIO_DITHER_EN in the model when the macro is defined.
module tb_pwm_audio_out;

   localparam int SW  = 12;
   localparam int PW  = 8;
   localparam int PER = 1 << PW;
   localparam int RES = 1 << (SW - PW);

   logic          clk = 1'b0;
   logic          n_rst;
   logic          enable;
   logic [SW-1:0] sample;
   logic          sample_valid;
   logic          sample_ready;
   logic          pwm_out;
   logic          period_start;
   logic          underrun;

   always #5 clk = ~clk;

   pwm_audio_out #(.SAMPLE_W(SW), .PWM_W(PW)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .enable       (enable),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .underrun     (underrun)
   );

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;
   int ur_count = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase = position within the current PWM period, -1 when not playing.
   int m_phase, m_duty, m_shadow, m_res;
   bit m_full, e_pwm, e_ps, e_ur;

   function automatic int take(input int s);
      int d;
`ifdef PWM_AUDIO_DITHER_EN
      int sum;
      sum   = (s % RES) + m_res;
      m_res = sum % RES;
      d     = s / RES + sum / RES;
      if (d > PER - 1) d = PER - 1;
`else
      d = s / RES;
`endif
      return d;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_phase = -1; m_duty = 0; m_shadow = 0; m_res = 0;
         m_full = 0; e_pwm = 0; e_ps = 0; e_ur = 0;
      end else begin
         bit acc;
         acc   = sample_valid && !m_full;
         e_pwm = (m_phase >= 0) && (m_phase < m_duty);
         e_ps  = 0;
         e_ur  = 0;
         if (!enable) begin
            m_phase = -1; e_pwm = 0; m_res = 0;
         end else if (m_phase < 0) begin
            if (m_full) begin
               m_duty = take(m_shadow); m_full = 0; m_phase = 0; e_ps = 1;
            end else begin
               m_res = 0;
            end
         end else if (m_phase == PER - 1) begin
            m_phase = 0; e_ps = 1;
            if (m_full) begin
               m_duty = take(m_shadow); m_full = 0;
            end else begin
               e_ur = 1;
            end
         end else begin
            m_phase++;
         end
         if (acc) begin
            m_shadow = int'(sample); m_full = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (underrun === 1'b1) ur_count++;
      if (check_en) begin
         chk("pwm_out",      pwm_out,      e_pwm);
         chk("period_start", period_start, e_ps);
         chk("underrun",     underrun,     e_ur);
         chk("sample_ready", sample_ready, !m_full);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [SW-1:0] s, output int waited);
      bit ok;
      waited       = 0;
      sample       = s;
      sample_valid = 1'b1;
      do begin
         ok = sample_ready;
         tick(1);
         if (!ok) waited++;
      end while (!ok && waited < 2000);
      if (!ok) chk("send_timeout", ok, 1);
      sample_valid = 1'b0;
   endtask

   task automatic wait_ps();
      int  n;
      bit  got;
      n   = 0;
      got = 0;
      while (!got && n < 1000) begin
         @(negedge clk);
         got = (period_start === 1'b1);
         n++;
      end
      if (!got) chk("period_start_timeout", got, 1);
   endtask

   // Counts pwm highs over the 256 cycles that follow a period_start.
   task automatic measure(output int highs, output int ur);
      wait_ps();
      ur    = int'(underrun);
      highs = 0;
      repeat (PER) begin
         @(negedge clk);
         if (pwm_out === 1'b1) highs++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, u, w, ur0, seen_ps, seen_hi, blocked;
      logic [SW-1:0] ext [3];
      int            ext_exp [3];

      n_rst = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
      tick(3);
      chk("reset_pwm",   pwm_out, 0);
      chk("reset_ready", sample_ready, 1);
      chk("reset_ps",    period_start, 0);
      chk("reset_ur",    underrun, 0);
      n_rst    = 1'b1;
      check_en = 1'b1;
      tick(2);

      // Midscale: 128 high per period, underrun on every repeated period.
      enable = 1'b1;
      send(12'h800, w);
      measure(h, u);
      chk("mid_highs_p1", h, 128);
      chk("mid_ur_p1",    u, 0);
      measure(h, u);
      chk("mid_highs_p2", h, 128);
      chk("mid_ur_p2",    u, 1);

      // Extremes, each loaded from IDLE.
      ext[0] = 12'h000; ext_exp[0] = 0;
      ext[1] = 12'hFFF; ext_exp[1] = 255;
      ext[2] = 12'h00F; ext_exp[2] = 0;
      for (int i = 0; i < 3; i++) begin
         enable = 1'b0;
         tick(2);
         chk("idle_pwm_low", pwm_out, 0);
         send(ext[i], w);
         enable = 1'b1;
         measure(h, u);
         chk($sformatf("extreme_highs_%0d", i), h, ext_exp[i]);
      end

      // Wrap-cycle accept with an empty shadow: underrun now, plays next period.
      enable = 1'b0;
      tick(2);
      send(12'h400, w);
      enable = 1'b1;
      measure(h, u);
      chk("q_highs", h, 64);
      repeat (PER - 1) @(posedge clk);
      #2;
      sample = 12'hC00; sample_valid = 1'b1;
      @(posedge clk);
      #2;
      sample_valid = 1'b0;
      @(negedge clk);
      chk("wrap_accept_ur",    underrun, 1);
      chk("wrap_accept_ready", sample_ready, 0);
      measure(h, u);
      chk("wrap_accept_highs", h, 192);
      chk("wrap_accept_no_ur", u, 0);

      // Streaming with backpressure: one sample every 200 cycles.
      send(12'h123, w);
      ur0     = ur_count;
      blocked = 0;
      for (int i = 0; i < 10; i++) begin
         tick(200);
         send(12'($urandom), w);
         if (w > 0) blocked++;
      end
      wait_ps();
      chk("stream_no_underrun", ur_count - ur0, 0);
      chk("stream_backpressure_seen", (blocked > 0), 1);

`ifdef PWM_AUDIO_DITHER_EN
      enable = 1'b0;
      tick(2);
      send(12'h808, w);
      enable = 1'b1;
      send(12'h808, w);
      measure(h, u);
      begin
         int h2;
         measure(h2, u);
         chk("dither_avg_sum", h + h2, 257);
         chk("dither_first",   h, 128);
      end
`endif

      // Random traffic with occasional enable drops.
      for (int i = 0; i < 4000; i++) begin
         sample_valid = ($urandom_range(0, 2) == 0);
         sample       = 12'($urandom);
         if ($urandom_range(0, 299) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         tick(1);
      end
      sample_valid = 1'b0;

      // Reset mid-RUN with pwm high and the shadow full.
      enable = 1'b0;
      tick(2);
      enable = 1'b1;
      send(12'h800, w);
      send(12'h900, w);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (pwm_out !== 1'b1 && n < 600);
         chk("pre_reset_pwm_high", pwm_out, 1);
      end
      #1;
      n_rst = 1'b0;
      #1;
      chk("reset_async_pwm",   pwm_out, 0);
      chk("reset_async_ready", sample_ready, 1);
      tick(2);
      n_rst   = 1'b1;
      seen_ps = 0;
      seen_hi = 0;
      repeat (300) begin
         @(negedge clk);
         if (period_start === 1'b1) seen_ps++;
         if (pwm_out === 1'b1) seen_hi++;
      end
      chk("post_reset_idle_ps", seen_ps, 0);
      chk("post_reset_idle_hi", seen_hi, 0);

      enable = 1'b0;
      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
